// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller: FSM states,
// VGA screen-select codes and the USB keycodes the sequencer reacts to.
package game_pkg;

    typedef enum logic [1:0] {
        TITLE      = 2'd0,
        TRANSITION = 2'd1,
        PLAY       = 2'd2,
        GAMEOVER   = 2'd3
    } game_state_t;

    localparam logic [1:0] SCR_START = 2'd0;
    localparam logic [1:0] SCR_PLAY  = 2'd1;
    localparam logic [1:0] SCR_OVER  = 2'd2;

    localparam logic [7:0] KEYC_ENTER = 8'h28;
    localparam logic [7:0] KEYC_1     = 8'h1E;
    localparam logic [7:0] KEYC_2     = 8'h1F;

    // The start screen stays up through the slide-out transition.
    function automatic logic [1:0] screenFor(input game_state_t state);
        case (state)
            PLAY:     screenFor = SCR_PLAY;
            GAMEOVER: screenFor = SCR_OVER;
            default:  screenFor = SCR_START;
        endcase
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Registers the previous keycode and raises a press pulse for each watched
// key only on the cycle its code first appears, so held keys fire once.
module key_edge_detect import game_pkg::*; #(
    parameter logic [7:0] KEY_ENTER = KEYC_ENTER,
    parameter logic [7:0] KEY_1     = KEYC_1,
    parameter logic [7:0] KEY_2     = KEYC_2
) (
    input  logic       i_clk,
    input  logic       i_rstN,
    input  logic [7:0] i_keycode,
    output logic       o_pressEnter,
    output logic       o_press1,
    output logic       o_press2
);

    logic [7:0] r_keyQ;

    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_keyQ <= 8'h00;
        end else begin
            r_keyQ <= i_keycode;
        end
    end

    assign o_pressEnter = (i_keycode == KEY_ENTER) && (r_keyQ != KEY_ENTER);
    assign o_press1     = (i_keycode == KEY_1)     && (r_keyQ != KEY_1);
    assign o_press2     = (i_keycode == KEY_2)     && (r_keyQ != KEY_2);

endmodule

// File: rtl/game_flow_controller.sv
// Top-level game sequencer: title screen, slide-out transition, timed play
// round and game-over hold, with all outputs registered from the next state.
module game_flow_controller import game_pkg::*; #(
    parameter int         FRAMES_PER_SEC = 60,
    parameter logic [7:0] ROUND_SECONDS  = 8'd60,
    parameter int         GAMEOVER_HOLD  = 180,
    parameter int         TRANS_TIMEOUT  = 255,
    parameter logic [7:0] KEY_ENTER      = KEYC_ENTER,
    parameter logic [7:0] KEY_1          = KEYC_1,
    parameter logic [7:0] KEY_2          = KEYC_2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_vs,
    input  logic [7:0] keycode,
    input  logic       transition_done,
    input  logic       crash,
    output logic       FrameTick,
    output logic       StartGame,
    output logic       StartTransition,
    output logic       PlayActive,
    output logic       GameOver,
    output logic       GameOverCause,
    output logic       NumPlayers,
    output logic [7:0] TimeLeft,
    output logic [1:0] ScreenSel
);

    localparam int FRAME_MAX = (TRANS_TIMEOUT > GAMEOVER_HOLD) ? TRANS_TIMEOUT : GAMEOVER_HOLD;
    localparam int FW        = $clog2(FRAME_MAX + 1);
    localparam int SW        = $clog2(FRAMES_PER_SEC);

    game_state_t r_state, w_nextState;
    logic          r_vsQ, r_frameTick;
    logic [FW-1:0] r_frameCnt, w_nextFrameCnt;
    logic [SW-1:0] r_secCnt, w_nextSecCnt;
    logic [7:0]    r_timeLeft, w_nextTimeLeft;
    logic          r_numPlayers, w_nextNumPlayers;
    logic          r_cause, w_nextCause;
    logic          r_startGame, r_startTransition, r_playActive, r_gameOver;
    logic [1:0]    r_screenSel;
    logic          w_pressEnter, w_press1, w_press2;

    key_edge_detect #(
        .KEY_ENTER (KEY_ENTER),
        .KEY_1     (KEY_1),
        .KEY_2     (KEY_2)
    ) u_keyEdge (
        .i_clk        (Clk),
        .i_rstN       (Reset_n),
        .i_keycode    (keycode),
        .o_pressEnter (w_pressEnter),
        .o_press1     (w_press1),
        .o_press2     (w_press2)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= TITLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState      = r_state;
        w_nextFrameCnt   = r_frameCnt;
        w_nextSecCnt     = r_secCnt;
        w_nextTimeLeft   = r_timeLeft;
        w_nextNumPlayers = r_numPlayers;
        w_nextCause      = r_cause;
        case (r_state)
            TITLE: begin
                if (w_press1) begin
                    w_nextNumPlayers = 1'b0;
                end else if (w_press2) begin
                    w_nextNumPlayers = 1'b1;
                end
                if (w_pressEnter) begin
                    w_nextState    = TRANSITION;
                    w_nextFrameCnt = '0;
                end
            end
            TRANSITION: begin
                if (r_frameTick) begin
                    w_nextFrameCnt = r_frameCnt + 1'b1;
                end
                if (transition_done ||
                    (r_frameTick && (r_frameCnt == FW'(TRANS_TIMEOUT - 1)))) begin
                    w_nextState    = PLAY;
                    w_nextTimeLeft = ROUND_SECONDS;
                    w_nextSecCnt   = '0;
                end
            end
            PLAY: begin
                // A crash freezes TimeLeft and wins over a simultaneous expiry.
                if (crash) begin
                    w_nextState    = GAMEOVER;
                    w_nextCause    = 1'b1;
                    w_nextFrameCnt = '0;
                end else if (r_frameTick) begin
                    if (r_secCnt == SW'(FRAMES_PER_SEC - 1)) begin
                        w_nextSecCnt = '0;
                        if (r_timeLeft != 8'd0) begin
                            w_nextTimeLeft = r_timeLeft - 8'd1;
                        end
                        if (r_timeLeft <= 8'd1) begin
                            w_nextState    = GAMEOVER;
                            w_nextCause    = 1'b0;
                            w_nextFrameCnt = '0;
                        end
                    end else begin
                        w_nextSecCnt = r_secCnt + 1'b1;
                    end
                end
            end
            GAMEOVER: begin
                if (r_frameTick) begin
                    w_nextFrameCnt = r_frameCnt + 1'b1;
                    if (r_frameCnt == FW'(GAMEOVER_HOLD - 1)) begin
                        w_nextState    = TITLE;
                        w_nextTimeLeft = 8'd0;
                        w_nextCause    = 1'b0;
                    end
                end
            end
            default: begin
                w_nextState = TITLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_vsQ             <= 1'b0;
            r_frameTick       <= 1'b0;
            r_frameCnt        <= '0;
            r_secCnt          <= '0;
            r_timeLeft        <= 8'd0;
            r_numPlayers      <= 1'b0;
            r_cause           <= 1'b0;
            r_startGame       <= 1'b0;
            r_startTransition <= 1'b0;
            r_playActive      <= 1'b0;
            r_gameOver        <= 1'b0;
            r_screenSel       <= SCR_START;
        end else begin
            r_vsQ             <= frame_vs;
            r_frameTick       <= frame_vs & ~r_vsQ;
            r_frameCnt        <= w_nextFrameCnt;
            r_secCnt          <= w_nextSecCnt;
            r_timeLeft        <= w_nextTimeLeft;
            r_numPlayers      <= w_nextNumPlayers;
            r_cause           <= w_nextCause;
            r_startGame       <= (w_nextState == TRANSITION) || (w_nextState == PLAY);
            r_startTransition <= (w_nextState == TRANSITION);
            r_playActive      <= (w_nextState == PLAY);
            r_gameOver        <= (w_nextState == GAMEOVER);
            r_screenSel       <= screenFor(w_nextState);
        end
    end

    assign FrameTick       = r_frameTick;
    assign StartGame       = r_startGame;
    assign StartTransition = r_startTransition;
    assign PlayActive      = r_playActive;
    assign GameOver        = r_gameOver;
    assign GameOverCause   = r_cause;
    assign NumPlayers      = r_numPlayers;
    assign TimeLeft        = r_timeLeft;
    assign ScreenSel       = r_screenSel;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with short timing parameters and
// hand-computed expectations for every phase of the game flow.
module tb_game_flow_controller;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_vs;
    logic [7:0] keycode;
    logic       transition_done;
    logic       crash;
    logic       FrameTick, StartGame, StartTransition, PlayActive;
    logic       GameOver, GameOverCause, NumPlayers;
    logic [7:0] TimeLeft;
    logic [1:0] ScreenSel;

    int total = 0;
    int bad   = 0;

    game_flow_controller #(
        .FRAMES_PER_SEC (4),
        .ROUND_SECONDS  (8'd3),
        .GAMEOVER_HOLD  (5),
        .TRANS_TIMEOUT  (10)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .frame_vs        (frame_vs),
        .keycode         (keycode),
        .transition_done (transition_done),
        .crash           (crash),
        .FrameTick       (FrameTick),
        .StartGame       (StartGame),
        .StartTransition (StartTransition),
        .PlayActive      (PlayActive),
        .GameOver        (GameOver),
        .GameOverCause   (GameOverCause),
        .NumPlayers      (NumPlayers),
        .TimeLeft        (TimeLeft),
        .ScreenSel       (ScreenSel)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // One vsync pulse; optionally raise crash in the cycle the tick is consumed.
    task automatic sendFrame(input logic crashAtTick);
        frame_vs = 1'b1;
        applyStimulus(1);
        frame_vs = 1'b0;
        crash    = crashAtTick;
        applyStimulus(1);
        crash    = 1'b0;
        applyStimulus(1);
    endtask

    task automatic sendFrames(input int n);
        for (int i = 0; i < n; i++) sendFrame(1'b0);
    endtask

    task automatic pressEnter();
        keycode = 8'h28;
        applyStimulus(1);
        keycode = 8'h00;
        applyStimulus(1);
    endtask

    task automatic enterPlay();
        pressEnter();
        transition_done = 1'b1;
        applyStimulus(1);
        transition_done = 1'b0;
    endtask

    initial begin
        Reset_n         = 1'b0;
        frame_vs        = 1'b0;
        keycode         = 8'h00;
        transition_done = 1'b0;
        crash           = 1'b0;
        applyStimulus(3);
        checkOutput("reset_screen", ScreenSel, 2'd0);
        checkOutput("reset_start",  StartGame, 1'b0);
        checkOutput("reset_time",   TimeLeft, 8'd0);
        Reset_n = 1'b1;
        applyStimulus(2);

        // Frame tick pulses once even with vsync held high
        frame_vs = 1'b1;
        applyStimulus(1);
        checkOutput("tick_pulse", FrameTick, 1'b1);
        applyStimulus(1);
        checkOutput("tick_held", FrameTick, 1'b0);
        frame_vs = 1'b0;
        applyStimulus(2);

        // Title: two-player key then held ENTER
        keycode = 8'h1F;
        applyStimulus(20);
        checkOutput("title_players", NumPlayers, 1'b1);
        checkOutput("title_startgame", StartGame, 1'b0);
        keycode = 8'h28;
        applyStimulus(50);
        checkOutput("trans_startgame", StartGame, 1'b1);
        checkOutput("trans_starttrans", StartTransition, 1'b1);
        checkOutput("trans_screen", ScreenSel, 2'd0);
        checkOutput("trans_notplay", PlayActive, 1'b0);
        keycode = 8'h00;
        applyStimulus(1);

        // Transition finished by the drawer after 3 frames
        sendFrames(3);
        checkOutput("trans_wait", PlayActive, 1'b0);
        transition_done = 1'b1;
        applyStimulus(1);
        transition_done = 1'b0;
        checkOutput("play_active", PlayActive, 1'b1);
        checkOutput("play_time", TimeLeft, 8'd3);
        checkOutput("play_starttrans", StartTransition, 1'b0);
        checkOutput("play_screen", ScreenSel, 2'd1);

        // Timer expiry: decrement every 4 frames, game over on frame 12
        sendFrames(3);
        checkOutput("time_f3", TimeLeft, 8'd3);
        sendFrames(1);
        checkOutput("time_f4", TimeLeft, 8'd2);
        sendFrames(4);
        checkOutput("time_f8", TimeLeft, 8'd1);
        sendFrames(3);
        checkOutput("time_f11_play", PlayActive, 1'b1);
        sendFrames(1);
        checkOutput("expire_over", GameOver, 1'b1);
        checkOutput("expire_cause", GameOverCause, 1'b0);
        checkOutput("expire_time", TimeLeft, 8'd0);
        checkOutput("expire_screen", ScreenSel, 2'd2);
        checkOutput("expire_startgame", StartGame, 1'b0);

        // Keys ignored during the hold; automatic return after 5 frames
        keycode = 8'h1E;
        applyStimulus(1);
        keycode = 8'h00;
        sendFrames(4);
        checkOutput("hold_over", GameOver, 1'b1);
        checkOutput("hold_players", NumPlayers, 1'b1);
        sendFrames(1);
        checkOutput("back_title_over", GameOver, 1'b0);
        checkOutput("back_title_screen", ScreenSel, 2'd0);
        checkOutput("back_title_players", NumPlayers, 1'b1);

        // Transition timeout forces play on the 10th frame
        pressEnter();
        checkOutput("to_trans", StartTransition, 1'b1);
        sendFrames(9);
        checkOutput("timeout_f9", StartTransition, 1'b1);
        sendFrames(1);
        checkOutput("timeout_play", PlayActive, 1'b1);
        checkOutput("timeout_time", TimeLeft, 8'd3);

        // Crash at TimeLeft=2 freezes the timer
        sendFrames(4);
        checkOutput("crash_pre_time", TimeLeft, 8'd2);
        crash = 1'b1;
        applyStimulus(1);
        crash = 1'b0;
        checkOutput("crash_over", GameOver, 1'b1);
        checkOutput("crash_cause", GameOverCause, 1'b1);
        checkOutput("crash_time", TimeLeft, 8'd2);
        sendFrames(5);
        checkOutput("crash_return", ScreenSel, 2'd0);

        // Crash coincides with the final decrement
        enterPlay();
        sendFrames(11);
        checkOutput("tie_pre_time", TimeLeft, 8'd1);
        sendFrame(1'b1);
        checkOutput("tie_over", GameOver, 1'b1);
        checkOutput("tie_cause", GameOverCause, 1'b1);
        sendFrames(5);
        checkOutput("tie_return", ScreenSel, 2'd0);

        // Asynchronous reset mid-play at TimeLeft=2
        enterPlay();
        sendFrames(4);
        checkOutput("rst_pre_time", TimeLeft, 8'd2);
        #3;
        Reset_n = 1'b0;
        #1;
        checkOutput("rst_async_play", PlayActive, 1'b0);
        checkOutput("rst_async_time", TimeLeft, 8'd0);
        checkOutput("rst_async_screen", ScreenSel, 2'd0);
        checkOutput("rst_async_players", NumPlayers, 1'b0);
        applyStimulus(1);
        Reset_n = 1'b1;
        applyStimulus(1);
        checkOutput("rst_title_start", StartGame, 1'b0);
        pressEnter();
        checkOutput("rst_title_enter", StartTransition, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
